// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: forwarding mux encodings,
// mul/div FSM states and watchdog default.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam int unsigned MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// fwd_sel: one ALU-operand forwarding comparator.
// Ports: rs (Execute source), rd/regwrite of Memory and Writeback, fwd select out.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       regwrite_m_i,
  input  logic       regwrite_w_i,
  output logic [1:0] fwd_o
);

  fwd_e sel;

  // Memory stage holds the younger result, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (regwrite_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
      sel = FWD_MEM;
    end else if (regwrite_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
      sel = FWD_WB;
    end
  end

  assign fwd_o = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use / mul-div stalls, branch flushes,
// mul/div watchdog and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MdStartE,
  input  logic        MdDoneE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MdBusy,
  output logic        MdTimeout,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  localparam int WDW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(MD_TIMEOUT - 1);

  md_state_e      state_q, state_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           tmo_q, tmo_d;
  logic [31:0]    stall_cnt_q, stall_cnt_d;
  logic [31:0]    flush_cnt_q, flush_cnt_d;
  logic           lw_stall;
  logic           md_stall;

  fwd_sel u_fwd_a (
    .rs_i         (Rs1E),
    .rd_m_i       (RdM),
    .rd_w_i       (RdW),
    .regwrite_m_i (RegWriteM),
    .regwrite_w_i (RegWriteW),
    .fwd_o        (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs_i         (Rs2E),
    .rd_m_i       (RdM),
    .rd_w_i       (RdW),
    .regwrite_m_i (RegWriteM),
    .regwrite_w_i (RegWriteW),
    .fwd_o        (ForwardBE)
  );

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));

  // A start that completes in the same cycle never stalls.
  assign md_stall = ((state_q == MD_IDLE) && MdStartE && !MdDoneE) ||
                    ((state_q == MD_WAIT) && !MdDoneE);

  assign StallF    = lw_stall | md_stall;
  assign StallD    = lw_stall | md_stall;
  assign StallE    = md_stall;
  assign FlushM    = md_stall;
  assign FlushD    = PCSrcE && !md_stall;
  assign FlushE    = (lw_stall | PCSrcE) && !md_stall;
  assign MdBusy    = (state_q == MD_WAIT);
  assign MdTimeout = tmo_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (MdStartE && !MdDoneE) begin
          state_d = MD_WAIT;
          wd_d    = '0;
        end
      end
      MD_WAIT: begin
        if (MdDoneE) begin
          state_d = MD_IDLE;
        end else if (wd_q == WD_LAST) begin
          // Watchdog: give up and release the pipeline.
          state_d = MD_IDLE;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (FlushD | FlushE) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      wd_q        <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of combinational vectors plus
// hand sequences for mul/div, watchdog, counters and reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
  logic        MdStartE, MdDoneE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic        MdBusy, MdTimeout;
  logic [31:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MdStartE(MdStartE), .MdDoneE(MdDoneE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .MdTimeout(MdTimeout),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lde, pcsrc, rwm, rww;
    logic [1:0] fa, fb;
    logic       stf, fld, fle;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MdStartE = 0; MdDoneE = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_lw();
    ResultSrcE0 = 1; RdE = 5'd3; Rs2D = 5'd3;
  endtask

  logic [31:0] sc0, fc0;
  int n;

  initial begin
    //       rs1d rs2d rs1e rs2e rde rdm rdw lde pc rwm rww fa     fb     stf fld fle
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vt[1]  = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0};
    vt[2]  = '{0, 0, 5, 0, 0, 0, 5, 0, 0, 1, 1, 2'b01, 2'b00, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 7, 0, 7, 7, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0};
    vt[4]  = '{0, 0, 9, 9, 0, 9, 4, 0, 0, 1, 1, 2'b10, 2'b10, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0};
    vt[6]  = '{0, 3, 0, 0, 3, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vt[8]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
    vt[10] = '{6, 0, 0, 0, 6, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 1, 1};

    clr();
    rst = 1'b1;
    @(negedge clk);
    step();
    // counters must not move while rst is held, even with stall/flush active
    set_lw(); PCSrcE = 1;
    step();
    #1;
    chk("rst_stallf_comb", {31'd0, StallF}, 32'd1);
    chk("rst_stallcnt", StallCount, 32'd0);
    chk("rst_flushcnt", FlushCount, 32'd0);
    chk("rst_busy", {31'd0, MdBusy}, 32'd0);
    chk("rst_tmo", {31'd0, MdTimeout}, 32'd0);
    clr();
    rst = 1'b0;
    step();

    foreach (vt[i]) begin
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e;
      Rs2E = vt[i].rs2e; RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
      ResultSrcE0 = vt[i].lde; PCSrcE = vt[i].pcsrc;
      RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
      #1;
      chk($sformatf("v%0d_fa", i), {30'd0, ForwardAE}, {30'd0, vt[i].fa});
      chk($sformatf("v%0d_fb", i), {30'd0, ForwardBE}, {30'd0, vt[i].fb});
      chk($sformatf("v%0d_stf", i), {31'd0, StallF}, {31'd0, vt[i].stf});
      chk($sformatf("v%0d_std", i), {31'd0, StallD}, {31'd0, vt[i].stf});
      chk($sformatf("v%0d_ste", i), {31'd0, StallE}, 32'd0);
      chk($sformatf("v%0d_fld", i), {31'd0, FlushD}, {31'd0, vt[i].fld});
      chk($sformatf("v%0d_fle", i), {31'd0, FlushE}, {31'd0, vt[i].fle});
      chk($sformatf("v%0d_flm", i), {31'd0, FlushM}, 32'd0);
      step();
    end
    clr();

    // load-use: one stall cycle, counter +1
    do_reset();
    sc0 = StallCount;
    set_lw();
    #1;
    chk("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    step();
    clr();
    #1;
    chk("lu_release", {31'd0, StallF}, 32'd0);
    chk("lu_cnt", StallCount - sc0, 32'd1);

    // branch plus load-use: both flushes, one flush count
    fc0 = FlushCount;
    set_lw(); PCSrcE = 1;
    #1;
    chk("br_lu_fl", {30'd0, FlushD, FlushE}, 32'd3);
    step();
    clr();
    #1;
    chk("br_lu_fcnt", FlushCount - fc0, 32'd1);

    // same-cycle start/done stays idle and does not stall
    MdStartE = 1; MdDoneE = 1;
    #1;
    chk("md_fast_stall", {31'd0, StallE}, 32'd0);
    step();
    clr();
    #1;
    chk("md_fast_busy", {31'd0, MdBusy}, 32'd0);

    // mul/div done 4 cycles after the start pulse
    MdStartE = 1;
    #1;
    chk("md_c0", {29'd0, MdBusy, StallE, FlushM}, 32'd3);
    step();
    MdStartE = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin
        set_lw(); PCSrcE = 1;
      end
      #1;
      chk($sformatf("md_c%0d", c), {29'd0, MdBusy, StallE, FlushM}, 32'd7);
      chk($sformatf("md_c%0d_fl", c), {30'd0, FlushD, FlushE}, 32'd0);
      chk($sformatf("md_c%0d_sf", c), {31'd0, StallF}, 32'd1);
      step();
      clr();
    end
    MdDoneE = 1;
    #1;
    chk("md_c4", {29'd0, MdBusy, StallE, FlushM}, 32'd4);
    chk("md_c4_sf", {31'd0, StallF}, 32'd0);
    step();
    clr();
    #1;
    chk("md_c5_busy", {31'd0, MdBusy}, 32'd0);
    chk("md_no_tmo", {31'd0, MdTimeout}, 32'd0);

    // watchdog: 8 waiting cycles then release with sticky flag
    MdStartE = 1;
    step();
    MdStartE = 0;
    n = 0;
    while (MdBusy && n < 20) begin
      #1;
      if (StallF !== 1'b1) chk("wd_stall_hold", {31'd0, StallF}, 32'd1);
      n++;
      step();
    end
    chk("wd_cycles", n, 32'd8);
    #1;
    chk("wd_tmo", {31'd0, MdTimeout}, 32'd1);
    chk("wd_release", {30'd0, StallF, MdBusy}, 32'd0);
    repeat (3) step();
    chk("wd_sticky", {31'd0, MdTimeout}, 32'd1);
    do_reset();
    #1;
    chk("wd_rst_clr", {31'd0, MdTimeout}, 32'd0);

    // reset while waiting aborts the operation
    MdStartE = 1;
    step();
    MdStartE = 0;
    step();
    rst = 1;
    #1;
    chk("abort_in_rst", {31'd0, StallE}, 32'd1);
    step();
    rst = 0;
    #1;
    chk("abort_after", {30'd0, StallE, MdBusy}, 32'd0);

    // stall counter wraps
    set_lw();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("wrap_pre", StallCount, 32'hFFFF_FFFF);
    step();
    clr();
    #1;
    chk("wrap_post", StallCount, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
